// File: rtl/phase_sel_pkg.sv
// phase_sel_pkg: shared types and helpers for phase_sel_match_fsm.
//   state_e    : FSM state encoding (3-bit)
//   HOLD_CNT_W : width of the hold_cnt output port
//   is_onehot  : exactly-one-bit-set test on a select value zero-extended to 8 bits
package phase_sel_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    CHECK = 3'd2,
    MATCH = 3'd3,
    FAIL  = 3'd4
  } state_e;

  localparam int HOLD_CNT_W = 4;

  // Selects are at most 8 bits wide, so callers zero-extend into this function.
  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/phase_sel_lane.sv
// phase_sel_lane: per-channel pass test.
//   i_sel  : registered one-hot phase select
//   i_ch   : registered channel field
//   o_pass : 1 when the selected phase bit of the channel is set
module phase_sel_lane #(
  parameter int PHASES = 3
) (
  input  logic [PHASES-1:0] i_sel,
  input  logic [PHASES-1:0] i_ch,
  output logic              o_pass
);

  assign o_pass = |(i_sel & i_ch);

endmodule

// File: rtl/phase_sel_match_fsm.sv
// phase_sel_match_fsm: registers the channel status fields and the one-hot
// phase select, reduces them to an all-pass flag, and qualifies that flag
// over HOLD consecutive samples to produce a match or fail verdict.
//
// Ports:
//   CK, RN    : clock (rising edge), asynchronous active-low reset
//   en        : global enable, low forces IDLE and clears the verdict
//   arm       : start request (ignored outside IDLE)
//   clr       : synchronous verdict clear / abort
//   sel       : one-hot phase select (PHASES bits)
//   ch_bits   : channel fields, channel i at [i*PHASES +: PHASES]
//   busy      : FSM in ARMED or CHECK
//   match_o   : HOLD consecutive all-pass samples seen
//   fail_o    : a failing sample was seen
//   sel_err   : sticky, an illegal (not one-hot) select was sampled in CHECK
//   hold_cnt  : consecutive all-pass count, zero-extended to 4 bits
//   fail_idx  : (PHASE_SEL_FAIL_CAPTURE_EN only) lowest failing channel index
//
// Optional feature macro: PHASE_SEL_FAIL_CAPTURE_EN adds the fail_idx capture.
module phase_sel_match_fsm
  import phase_sel_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int PHASES = 3,
  parameter int HOLD   = 4,
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     CK,
  input  logic                     RN,
  input  logic                     en,
  input  logic                     arm,
  input  logic                     clr,
  input  logic [PHASES-1:0]        sel,
  input  logic [NUM_CH*PHASES-1:0] ch_bits,
  output logic                     busy,
  output logic                     match_o,
  output logic                     fail_o,
  output logic                     sel_err,
  output logic [HOLD_CNT_W-1:0]    hold_cnt
`ifdef PHASE_SEL_FAIL_CAPTURE_EN
  ,
  output logic [IDX_W-1:0]         fail_idx
`endif
);

  // Stage 1: unconditional input capture.
  logic [PHASES-1:0]        r_sel_q;
  logic [NUM_CH*PHASES-1:0] r_ch_q;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_sel_q <= '0;
      r_ch_q  <= '0;
    end else begin
      r_sel_q <= sel;
      r_ch_q  <= ch_bits;
    end
  end

  // Stage 2: per-lane pass, all-pass reduction, select legality.
  logic [NUM_CH-1:0] w_pass;
  logic              w_all_pass;
  logic              w_onehot;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    phase_sel_lane #(.PHASES(PHASES)) u_lane (
      .i_sel  (r_sel_q),
      .i_ch   (r_ch_q[gi*PHASES +: PHASES]),
      .o_pass (w_pass[gi])
    );
  end

  assign w_all_pass = &w_pass;
  assign w_onehot   = is_onehot(8'(r_sel_q));

  // FSM and verdict registers.
  state_e                r_state, w_state_nxt;
  logic                  r_match, w_match_nxt;
  logic                  r_fail,  w_fail_nxt;
  logic                  r_sel_err, w_sel_err_nxt;
  logic [HOLD_CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [HOLD_CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_hold_cnt + HOLD_CNT_W'(1);

`ifdef PHASE_SEL_FAIL_CAPTURE_EN
  logic [IDX_W-1:0] r_fail_idx, w_fail_idx_nxt, w_first_fail;

  // Scan downward so the lowest failing index is the last one written.
  always_comb begin
    w_first_fail = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!w_pass[i]) w_first_fail = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_match_nxt    = r_match;
    w_fail_nxt     = r_fail;
    w_sel_err_nxt  = r_sel_err;
    w_hold_cnt_nxt = r_hold_cnt;
`ifdef PHASE_SEL_FAIL_CAPTURE_EN
    w_fail_idx_nxt = r_fail_idx;
`endif
    if (!en || clr) begin
      // Disable and clear share the same teardown; only clr from IDLE
      // also drops the sticky select error.
      w_state_nxt    = IDLE;
      w_match_nxt    = 1'b0;
      w_fail_nxt     = 1'b0;
      w_hold_cnt_nxt = '0;
`ifdef PHASE_SEL_FAIL_CAPTURE_EN
      w_fail_idx_nxt = '0;
`endif
      if (en && r_state == IDLE) w_sel_err_nxt = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (arm) begin
            w_state_nxt    = ARMED;
            w_hold_cnt_nxt = '0;
          end
        end
        ARMED: w_state_nxt = CHECK;
        CHECK: begin
          if (!w_onehot) begin
            w_sel_err_nxt = 1'b1;
          end else if (w_all_pass) begin
            w_hold_cnt_nxt = w_cnt_inc;
            // Count never exceeds HOLD: reaching it leaves CHECK.
            if (w_cnt_inc == HOLD_CNT_W'(HOLD)) begin
              w_state_nxt = MATCH;
              w_match_nxt = 1'b1;
            end
          end else begin
            w_state_nxt    = FAIL;
            w_fail_nxt     = 1'b1;
            w_hold_cnt_nxt = '0;
`ifdef PHASE_SEL_FAIL_CAPTURE_EN
            w_fail_idx_nxt = w_first_fail;
`endif
          end
        end
        MATCH, FAIL: ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state    <= IDLE;
      r_match    <= 1'b0;
      r_fail     <= 1'b0;
      r_sel_err  <= 1'b0;
      r_hold_cnt <= '0;
`ifdef PHASE_SEL_FAIL_CAPTURE_EN
      r_fail_idx <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_match    <= w_match_nxt;
      r_fail     <= w_fail_nxt;
      r_sel_err  <= w_sel_err_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
`ifdef PHASE_SEL_FAIL_CAPTURE_EN
      r_fail_idx <= w_fail_idx_nxt;
`endif
    end
  end

  assign busy     = (r_state == ARMED) || (r_state == CHECK);
  assign match_o  = r_match;
  assign fail_o   = r_fail;
  assign sel_err  = r_sel_err;
  assign hold_cnt = r_hold_cnt;
`ifdef PHASE_SEL_FAIL_CAPTURE_EN
  assign fail_idx = r_fail_idx;
`endif

endmodule

// File: tb/tb_phase_sel_match_fsm.sv
module tb_phase_sel_match_fsm;

  localparam int NC = 8;
  localparam int PH = 3;

  logic          CK = 1'b0;
  logic          RN;
  logic          en, arm, clr;
  logic [PH-1:0] sel;
  logic [NC*PH-1:0] ch_bits;
  logic          busy, match_o, fail_o, sel_err;
  logic [3:0]    hold_cnt;
`ifdef PHASE_SEL_FAIL_CAPTURE_EN
  logic [2:0]    fail_idx;
`endif

  phase_sel_match_fsm #(.NUM_CH(NC), .PHASES(PH), .HOLD(4)) dut (
    .CK       (CK),
    .RN       (RN),
    .en       (en),
    .arm      (arm),
    .clr      (clr),
    .sel      (sel),
    .ch_bits  (ch_bits),
    .busy     (busy),
    .match_o  (match_o),
    .fail_o   (fail_o),
    .sel_err  (sel_err),
    .hold_cnt (hold_cnt)
`ifdef PHASE_SEL_FAIL_CAPTURE_EN
    ,
    .fail_idx (fail_idx)
`endif
  );

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      nm;
    logic       b, m, f, e;
    logic [3:0] c;
    logic [2:0] ix;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  task automatic exp(input int dc, input string nm, input logic b, input logic m,
                     input logic f, input logic e, input logic [3:0] c,
                     input logic [2:0] ix);
    exp_t x;
    x.cyc = cyc + dc; x.nm = nm; x.b = b; x.m = m; x.f = f; x.e = e;
    x.c = c; x.ix = ix;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge CK);
    #2;
  endtask

  always @(negedge CK) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      logic bad;
      cur = q.pop_front();
      checks++;
      bad = (cur.cyc != cyc) || ({busy, match_o, fail_o, sel_err, hold_cnt} !=
                                 {cur.b, cur.m, cur.f, cur.e, cur.c});
`ifdef PHASE_SEL_FAIL_CAPTURE_EN
      if (fail_idx != cur.ix) bad = 1'b1;
`endif
      if (bad) begin
        errors++;
        $display("FAIL %s cyc=%0d(due %0d) got busy=%0b match=%0b fail=%0b sel_err=%0b cnt=%0d need busy=%0b match=%0b fail=%0b sel_err=%0b cnt=%0d idx=%0d",
                 cur.nm, cyc, cur.cyc, busy, match_o, fail_o, sel_err, hold_cnt,
                 cur.b, cur.m, cur.f, cur.e, cur.c, cur.ix);
      end
    end
  end

  logic [NC*PH-1:0] all_s, bad5;

  initial begin
    all_s = {NC{3'b010}};
    bad5  = all_s;
    bad5[17:15] = 3'b101;
    RN = 1'b0; en = 1'b0; arm = 1'b0; clr = 1'b0;
    sel = 3'b010; ch_bits = all_s;

    step();
    exp(0, "rst", 0, 0, 0, 0, 0, 0);
    step();
    RN = 1'b1; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp(1, "idle", 0, 0, 0, 0, 0, 0); step();
    end

    arm = 1'b1; exp(1, "A_arm",     1, 0, 0, 0, 0, 0); step();
    arm = 1'b0; exp(1, "A_flush",   1, 0, 0, 0, 0, 0); step();
    exp(1, "A_s1",                  1, 0, 0, 0, 1, 0); step();
    exp(1, "A_s2",                  1, 0, 0, 0, 2, 0); step();
    exp(1, "A_s3",                  1, 0, 0, 0, 3, 0); step();
    exp(1, "A_match",               0, 1, 0, 0, 4, 0); step();
    checks++;
    if (match_o !== 1'b1 || fail_o !== 1'b0 || hold_cnt !== 4'd4) begin
      errors++;
      $display("FAIL A_direct_match match=%0b fail=%0b cnt=%0d", match_o, fail_o, hold_cnt);
    end
    arm = 1'b1; exp(1, "A_arm_ign", 0, 1, 0, 0, 4, 0); step();
    arm = 1'b0; clr = 1'b1;
    exp(1, "A_clr",                 0, 0, 0, 0, 0, 0); step();
    clr = 1'b0; arm = 1'b1;
    exp(1, "A_rearm",               1, 0, 0, 0, 0, 0); step();
    arm = 1'b0; exp(1, "A_reflush", 1, 0, 0, 0, 0, 0); step();
    exp(1, "A_restart1",            1, 0, 0, 0, 1, 0); step();
    exp(1, "A_restart2",            1, 0, 0, 0, 2, 0); step();
    en = 1'b0; exp(1, "A_en_drop",  0, 0, 0, 0, 0, 0); step();
    en = 1'b1; step();

    arm = 1'b1; exp(1, "B_arm",     1, 0, 0, 0, 0, 0); step();
    arm = 1'b0; exp(1, "B_flush",   1, 0, 0, 0, 0, 0); step();
    ch_bits = bad5; exp(1, "B_s1",  1, 0, 0, 0, 1, 0); step();
    ch_bits = all_s; exp(1, "B_fail", 0, 0, 1, 0, 0, 5); step();
    checks++;
    if (fail_o !== 1'b1 || match_o !== 1'b0 || hold_cnt !== 4'd0) begin
      errors++;
      $display("FAIL B_direct_fail match=%0b fail=%0b cnt=%0d", match_o, fail_o, hold_cnt);
    end
    exp(1, "B_hold",                0, 0, 1, 0, 0, 5); step();
    clr = 1'b1; exp(1, "B_clr",     0, 0, 0, 0, 0, 0); step();
    clr = 1'b0; step();

    arm = 1'b1; exp(1, "C_arm",     1, 0, 0, 0, 0, 0); step();
    arm = 1'b0; exp(1, "C_flush",   1, 0, 0, 0, 0, 0); step();
    sel = 3'b011; exp(1, "C_s1",    1, 0, 0, 0, 1, 0); step();
    sel = 3'b010; exp(1, "C_illegal", 1, 0, 0, 1, 1, 0); step();
    checks++;
    if (sel_err !== 1'b1 || hold_cnt !== 4'd1) begin
      errors++;
      $display("FAIL C_direct_sel_err sel_err=%0b cnt=%0d", sel_err, hold_cnt);
    end
    exp(1, "C_s2",                  1, 0, 0, 1, 2, 0); step();
    exp(1, "C_s3",                  1, 0, 0, 1, 3, 0); step();
    exp(1, "C_match",               0, 1, 0, 1, 4, 0); step();
    clr = 1'b1; exp(1, "C_clr_keep_err", 0, 0, 0, 1, 0, 0); step();
    clr = 1'b0; en = 1'b0;
    exp(1, "C_en_keep_err",         0, 0, 0, 1, 0, 0); step();
    en = 1'b1; clr = 1'b1;
    exp(1, "C_clr_idle",            0, 0, 0, 0, 0, 0); step();
    clr = 1'b0; step();

    arm = 1'b1; exp(1, "D_arm",     1, 0, 0, 0, 0, 0); step();
    arm = 1'b0; exp(1, "D_flush",   1, 0, 0, 0, 0, 0); step();
    exp(1, "D_s1",                  1, 0, 0, 0, 1, 0); step();
    step();
    RN = 1'b0; exp(0, "D_async_rst", 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (busy !== 1'b0 || match_o !== 1'b0 || fail_o !== 1'b0 ||
        sel_err !== 1'b0 || hold_cnt !== 4'd0) begin
      errors++;
      $display("FAIL D_direct_async busy=%0b match=%0b fail=%0b sel_err=%0b cnt=%0d",
               busy, match_o, fail_o, sel_err, hold_cnt);
    end
    exp(1, "D_in_rst",              0, 0, 0, 0, 0, 0); step();
    RN = 1'b1; arm = 1'b1;
    exp(1, "D_rearm",               1, 0, 0, 0, 0, 0); step();
    arm = 1'b0; exp(1, "D_flush2",  1, 0, 0, 0, 0, 0); step();
    exp(1, "D_s1b",                 1, 0, 0, 0, 1, 0); step();
    exp(1, "D_s2b",                 1, 0, 0, 0, 2, 0); step();
    exp(1, "D_s3b",                 1, 0, 0, 0, 3, 0); step();
    exp(1, "D_match",               0, 1, 0, 0, 4, 0); step();

    step(); step(); step();
    while (q.size() > 0) begin
      cur = q.pop_front();
      checks++; errors++;
      $display("FAIL %s never checked (due cyc %0d, now %0d)", cur.nm, cur.cyc, cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
